pc_sequencer: RTL and testbench

//   Fetch/next-PC unit that drives the instruction stream into the main control decoder and acts on its

---
 rtl/pc_sequencer_if.sv | 33 +++
 rtl/pc_sequencer.sv | 142 ++++++++++++++
 tb/tb_pc_sequencer.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pc_sequencer_if.sv
// Fetch and decode-side signal bundle for pc_sequencer.
// The master modport is the sequencer; the slave modport is the imem/decoder environment.
interface pc_sequencer_if #(
    parameter int ADDR_W = 32
);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic [31:0]       imem_rdata;
    logic              instr_valid;
    logic              instr_ready;
    logic [31:0]       instr;
    logic [ADDR_W-1:0] pc_out;
    logic              branch;
    logic              zero;
    logic              jump;
    logic              jal;
    logic              jr;
    logic [ADDR_W-1:0] jr_target;
    logic [ADDR_W-1:0] link_addr;
    logic              link_valid;
    logic              misalign;

    modport master (
        output imem_req, imem_addr, instr_valid, instr, pc_out, link_addr, link_valid, misalign,
        input  imem_ack, imem_rdata, instr_ready, branch, zero, jump, jal, jr, jr_target
    );

    modport slave (
        input  imem_req, imem_addr, instr_valid, instr, pc_out, link_addr, link_valid, misalign,
        output imem_ack, imem_rdata, instr_ready, branch, zero, jump, jal, jr, jr_target
    );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch/next-PC unit feeding the control decoder; DELAY_SLOT_EN adds one branch delay slot.
// Latency: 3 cycles minimum per instruction (request, ack, accept); link_valid/misalign one cycle after accept.
// Backpressure: imem_req held until imem_ack; instr/pc_out held while instr_ready is low.
module pc_sequencer #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          reset,
    pc_sequencer_if.master bus
);
    typedef enum logic {
        FETCH,
        ISSUE
    } state_t;

    state_t            state, state_nx;
    logic              req_q, req_nx;
    logic [ADDR_W-1:0] pc, pc_nx;
    logic [31:0]       instr_q, instr_nx;
    logic [ADDR_W-1:0] link_q, link_nx;
    logic              link_vld_q, link_vld_nx;
    logic              mis_q, mis_nx;
    logic [ADDR_W-1:0] p4, tgt;
    logic              jr_mis;

`ifdef DELAY_SLOT_EN
    logic              pend, pend_nx;
    logic [ADDR_W-1:0] pend_tgt, pend_tgt_nx;
    logic              taken;

    assign taken = bus.jr | bus.jump | bus.jal | (bus.branch & bus.zero);
`endif

    assign jr_mis = bus.jr & (|bus.jr_target[1:0]);

    // Transfer target in priority order; falls through to p4 when nothing is taken.
    always_comb begin
        p4  = pc + ADDR_W'(4);
        tgt = p4;
        if (bus.jr) begin
            tgt = {bus.jr_target[ADDR_W-1:2], 2'b00};
        end else if (bus.jump || bus.jal) begin
            tgt = {p4[ADDR_W-1:28], instr_q[25:0], 2'b00};
        end else if (bus.branch && bus.zero) begin
            tgt = p4 + {{(ADDR_W-18){instr_q[15]}}, instr_q[15:0], 2'b00};
        end
    end

    always_comb begin
        state_nx    = state;
        req_nx      = req_q;
        pc_nx       = pc;
        instr_nx    = instr_q;
        link_nx     = link_q;
        link_vld_nx = 1'b0;
        mis_nx      = 1'b0;
`ifdef DELAY_SLOT_EN
        pend_nx     = pend;
        pend_tgt_nx = pend_tgt;
`endif
        case (state)
            FETCH: begin
                // First FETCH cycle only raises the request, so a stale ack is never taken.
                if (!req_q) begin
                    req_nx = 1'b1;
                end else if (bus.imem_ack) begin
                    instr_nx = bus.imem_rdata;
                    req_nx   = 1'b0;
                    state_nx = ISSUE;
                end
            end
            ISSUE: begin
                if (bus.instr_ready) begin
                    state_nx = FETCH;
`ifdef DELAY_SLOT_EN
                    if (pend) begin
                        pc_nx   = pend_tgt;
                        pend_nx = 1'b0;
                    end else begin
                        pc_nx = p4;
                        if (taken) begin
                            pend_nx     = 1'b1;
                            pend_tgt_nx = tgt;
                        end
                        if (bus.jal) begin
                            link_vld_nx = 1'b1;
                            link_nx     = p4 + ADDR_W'(4);
                        end
                        mis_nx = jr_mis;
                    end
`else
                    pc_nx = tgt;
                    if (bus.jal) begin
                        link_vld_nx = 1'b1;
                        link_nx     = p4;
                    end
                    mis_nx = jr_mis;
`endif
                end
            end
            default: state_nx = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= FETCH;
            req_q      <= 1'b0;
            pc         <= RESET_PC;
            instr_q    <= '0;
            link_q     <= '0;
            link_vld_q <= 1'b0;
            mis_q      <= 1'b0;
`ifdef DELAY_SLOT_EN
            pend       <= 1'b0;
            pend_tgt   <= '0;
`endif
        end else begin
            state      <= state_nx;
            req_q      <= req_nx;
            pc         <= pc_nx;
            instr_q    <= instr_nx;
            link_q     <= link_nx;
            link_vld_q <= link_vld_nx;
            mis_q      <= mis_nx;
`ifdef DELAY_SLOT_EN
            pend       <= pend_nx;
            pend_tgt   <= pend_tgt_nx;
`endif
        end
    end

    assign bus.imem_req    = req_q;
    assign bus.imem_addr   = pc;
    assign bus.instr_valid = (state == ISSUE);
    assign bus.instr       = instr_q;
    assign bus.pc_out      = pc;
    assign bus.link_addr   = link_q;
    assign bus.link_valid  = link_vld_q;
    assign bus.misalign    = mis_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// Testbench for pc_sequencer: directed scenarios plus randomized control mixes against a next-PC model.
module tb_pc_sequencer;
`ifdef DELAY_SLOT_EN
    localparam bit DS = 1'b1;
`else
    localparam bit DS = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    // Reference model state
    logic [31:0] m_pc, m_tgt, m_link;
    bit          m_pend;
    // Expectations and observations of the most recent instruction
    logic [31:0] exp_addr, exp_la;
    bit          exp_lv, exp_mis;
    logic [31:0] obs_addr, obs_instr, obs_pc, obs_la;
    bit          obs_lv, obs_mis, obs_to, obs_stable;

    pc_sequencer_if #(.ADDR_W(32)) bus ();

    pc_sequencer #(.ADDR_W(32), .RESET_PC(32'h0000_0000)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic drive_idle_ctrl();
        bus.branch    = 1'($urandom);
        bus.zero      = 1'($urandom);
        bus.jump      = 1'($urandom);
        bus.jal       = 1'($urandom);
        bus.jr        = 1'($urandom);
        bus.jr_target = $urandom;
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_tgt = 32'h0; m_link = 32'h0; m_pend = 1'b0;
    endtask

    task automatic model_accept(input logic [31:0] w, input bit br, z, jp, jl, jrr,
                                input logic [31:0] jt);
        logic [31:0] p4, t;
        bit          taken;
        int          off;
        p4 = m_pc + 32'd4;
        exp_lv = 1'b0; exp_mis = 1'b0; taken = 1'b1; t = 32'h0;
        if (m_pend) begin
            m_pc = m_tgt; m_pend = 1'b0;
        end else begin
            if (jrr) begin
                t = jt - (jt % 4);
                exp_mis = (jt % 4) != 0;
            end else if (jp || jl) begin
                t = (p4 & 32'hF000_0000) + (w % 32'h0400_0000) * 4;
            end else if (br && z) begin
                off = $signed(w[15:0]);
                t = p4 + 32'(off * 4);
            end else begin
                taken = 1'b0;
            end
            if (jl) begin
                exp_lv = 1'b1;
                m_link = DS ? m_pc + 32'd8 : p4;
            end
            if (taken && DS) begin
                m_pc = p4; m_tgt = t; m_pend = 1'b1;
            end else if (taken) m_pc = t;
            else m_pc = p4;
        end
        exp_la = m_link;
    endtask

    // One full fetch/issue/accept transaction; records observations and advances the model.
    task automatic run_instr(input logic [31:0] w, input bit br, z, jp, jl, jrr,
                             input logic [31:0] jt, input int ack_dly, input int rdy_dly);
        int n;
        obs_to = 1'b0; obs_stable = 1'b1; exp_addr = m_pc;
        n = 0;
        while (bus.imem_req !== 1'b1 && n < 20) begin drive_idle_ctrl(); @(negedge clk); n++; end
        if (bus.imem_req !== 1'b1) obs_to = 1'b1;
        obs_addr = bus.imem_addr;
        repeat (ack_dly) begin
            drive_idle_ctrl();
            @(negedge clk);
            if (bus.imem_req !== 1'b1 || bus.imem_addr !== obs_addr) obs_stable = 1'b0;
        end
        bus.imem_ack = 1'b1; bus.imem_rdata = w;
        @(negedge clk);
        bus.imem_ack = 1'b0; bus.imem_rdata = $urandom;
        n = 0;
        while (bus.instr_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        if (bus.instr_valid !== 1'b1) obs_to = 1'b1;
        obs_instr = bus.instr; obs_pc = bus.pc_out;
        repeat (rdy_dly) begin
            drive_idle_ctrl();
            @(negedge clk);
            if (bus.instr_valid !== 1'b1 || bus.instr !== obs_instr || bus.pc_out !== obs_pc)
                obs_stable = 1'b0;
        end
        bus.instr_ready = 1'b1;
        bus.branch = br; bus.zero = z; bus.jump = jp; bus.jal = jl; bus.jr = jrr; bus.jr_target = jt;
        @(negedge clk);
        bus.instr_ready = 1'b0;
        drive_idle_ctrl();
        obs_lv = bus.link_valid; obs_mis = bus.misalign; obs_la = bus.link_addr;
        model_accept(w, br, z, jp, jl, jrr, jt);
    endtask

    task automatic run_nop();
        run_instr(32'h0000_0000, 0, 0, 0, 0, 0, 32'h0, 0, 0);
    endtask

    task automatic steer(input logic [31:0] target);
        run_instr(32'h0000_0008, 0, 0, 0, 0, 1, target, 0, 0);
        if (m_pend) run_nop();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        model_reset();
        checks += 6;
        if (bus.imem_req !== 1'b0) begin failures++; $display("FAIL reset_req: got %b expected 0", bus.imem_req); end
        if (bus.instr_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", bus.instr_valid); end
        if (bus.instr !== 32'h0) begin failures++; $display("FAIL reset_instr: got %h expected 0", bus.instr); end
        if (bus.link_addr !== 32'h0) begin failures++; $display("FAIL reset_link_addr: got %h expected 0", bus.link_addr); end
        if (bus.link_valid !== 1'b0) begin failures++; $display("FAIL reset_link_valid: got %b expected 0", bus.link_valid); end
        if (bus.misalign !== 1'b0) begin failures++; $display("FAIL reset_misalign: got %b expected 0", bus.misalign); end
        reset = 1'b0;
        @(negedge clk);
        checks += 2;
        if (bus.imem_req !== 1'b1) begin failures++; $display("FAIL first_req: got %b expected 1", bus.imem_req); end
        if (bus.imem_addr !== 32'h0) begin failures++; $display("FAIL first_addr: got %h expected 0", bus.imem_addr); end
    endtask

    task automatic test_first_fetch();
        run_instr(32'h0000_0020, 0, 0, 0, 0, 0, 32'h0, 0, 0);
        checks += 3;
        if (obs_to) begin failures++; $display("FAIL first_timeout: handshake did not complete"); end
        if (obs_instr !== 32'h0000_0020) begin failures++; $display("FAIL first_instr: got %h expected 00000020", obs_instr); end
        if (obs_pc !== 32'h0) begin failures++; $display("FAIL first_pc_out: got %h expected 0", obs_pc); end
    endtask

    task automatic test_straight();
        for (int i = 1; i < 4; i++) begin
            run_instr($urandom, 0, 0, 0, 0, 0, 32'h0, $urandom_range(0, 2), (i == 2) ? 5 : 0);
            checks += 2;
            if (obs_addr !== 32'(i * 4)) begin failures++; $display("FAIL straight_addr%0d: got %h expected %h", i, obs_addr, 32'(i * 4)); end
            if (obs_to || !obs_stable) begin failures++; $display("FAIL straight_hold%0d: timeout=%b stable=%b expected 0/1", i, obs_to, obs_stable); end
        end
    endtask

    task automatic test_branch();
        run_instr(32'h1000_FFFE, 1, 1, 0, 0, 0, 32'h0, 0, 0);
        checks++;
        if (obs_addr !== 32'h10) begin failures++; $display("FAIL beq_pc: got %h expected 00000010", obs_addr); end
        if (m_pend) run_nop();
        run_nop();
        checks++;
        if (obs_addr !== 32'h0C) begin failures++; $display("FAIL beq_taken_target: got %h expected 0000000c", obs_addr); end
        run_instr(32'h1000_FFFE, 1, 0, 0, 0, 0, 32'h0, 1, 1);
        run_nop();
        checks++;
        if (obs_addr !== 32'h14) begin failures++; $display("FAIL beq_not_taken: got %h expected 00000014", obs_addr); end
    endtask

    task automatic test_jal();
        steer(32'h40);
        run_instr(32'h0C00_0100, 0, 0, 0, 1, 0, 32'h0, 0, 0);
        checks += 3;
        if (obs_addr !== 32'h40) begin failures++; $display("FAIL jal_pc: got %h expected 00000040", obs_addr); end
        if (obs_lv !== 1'b1) begin failures++; $display("FAIL jal_link_valid: got %b expected 1", obs_lv); end
        if (obs_la !== (DS ? 32'h48 : 32'h44)) begin failures++; $display("FAIL jal_link_addr: got %h expected %h", obs_la, DS ? 32'h48 : 32'h44); end
        @(negedge clk);
        checks++;
        if (bus.link_valid !== 1'b0) begin failures++; $display("FAIL jal_pulse_width: got %b expected 0", bus.link_valid); end
        if (m_pend) begin
            run_nop();
            checks++;
            if (obs_addr !== 32'h44) begin failures++; $display("FAIL jal_slot_addr: got %h expected 00000044", obs_addr); end
        end
        run_nop();
        checks++;
        if (obs_addr !== 32'h400) begin failures++; $display("FAIL jal_target: got %h expected 00000400", obs_addr); end
    endtask

    task automatic test_jr_wrap();
        run_instr(32'h0000_0008, 0, 0, 0, 0, 1, 32'h123, 0, 0);
        checks++;
        if (obs_mis !== 1'b1) begin failures++; $display("FAIL jr_misalign: got %b expected 1", obs_mis); end
        if (m_pend) run_nop();
        run_nop();
        checks += 2;
        if (obs_addr !== 32'h120) begin failures++; $display("FAIL jr_target: got %h expected 00000120", obs_addr); end
        if (obs_mis !== 1'b0) begin failures++; $display("FAIL jr_misalign_clear: got %b expected 0", obs_mis); end
        steer(32'hFFFF_FFFC);
        run_nop();
        run_nop();
        checks++;
        if (obs_addr !== 32'h0) begin failures++; $display("FAIL pc_wrap: got %h expected 00000000", obs_addr); end
    endtask

    task automatic test_reset_midflight();
        int n = 0;
        while (bus.imem_req !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        reset = 1'b1;
        @(negedge clk);
        checks += 2;
        if (bus.imem_req !== 1'b0) begin failures++; $display("FAIL rst_fetch_req: got %b expected 0", bus.imem_req); end
        if (bus.instr_valid !== 1'b0) begin failures++; $display("FAIL rst_fetch_valid: got %b expected 0", bus.instr_valid); end
        reset = 1'b0;
        model_reset();
        bus.imem_ack = 1'b1; bus.imem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        bus.imem_ack = 1'b0;
        checks += 2;
        if (bus.instr_valid !== 1'b0) begin failures++; $display("FAIL late_ack_ignored: valid got %b expected 0", bus.instr_valid); end
        if (bus.imem_req !== 1'b1) begin failures++; $display("FAIL late_ack_req: got %b expected 1", bus.imem_req); end
        bus.imem_ack = 1'b1; bus.imem_rdata = 32'h1111_1111;
        @(negedge clk);
        bus.imem_ack = 1'b0;
        n = 0;
        while (bus.instr_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        checks += 3;
        if (bus.instr_valid !== 1'b0) begin failures++; $display("FAIL rst_issue_valid: got %b expected 0", bus.instr_valid); end
        if (bus.imem_req !== 1'b0) begin failures++; $display("FAIL rst_issue_req: got %b expected 0", bus.imem_req); end
        if (bus.instr !== 32'h0) begin failures++; $display("FAIL rst_issue_instr: got %h expected 0", bus.instr); end
        run_instr(32'h2222_2222, 0, 0, 0, 0, 0, 32'h0, 0, 0);
        checks += 2;
        if (obs_addr !== 32'h0) begin failures++; $display("FAIL refetch_addr: got %h expected 0", obs_addr); end
        if (obs_instr !== 32'h2222_2222) begin failures++; $display("FAIL refetch_instr: got %h expected 22222222", obs_instr); end
    endtask

    task automatic test_random();
        logic [31:0] w, jt;
        bit br, z, jp, jl, jrr;
        for (int i = 0; i < 60; i++) begin
            w = $urandom; jt = $urandom;
            {br, z, jp, jl, jrr} = 5'b0;
            case ($urandom_range(0, 5))
                1: begin br = 1'b1; z = 1'($urandom); end
                2: jp = 1'b1;
                3: jl = 1'b1;
                4: jrr = 1'b1;
                5: {br, z, jp, jl, jrr} = 5'($urandom);
                default: ;
            endcase
            run_instr(w, br, z, jp, jl, jrr, jt, $urandom_range(0, 3), $urandom_range(0, 3));
            checks += 6;
            if (obs_to || !obs_stable) begin failures++; $display("FAIL rnd%0d_handshake: timeout=%b stable=%b expected 0/1", i, obs_to, obs_stable); end
            if (obs_addr !== exp_addr) begin failures++; $display("FAIL rnd%0d_addr: got %h expected %h", i, obs_addr, exp_addr); end
            if (obs_instr !== w) begin failures++; $display("FAIL rnd%0d_instr: got %h expected %h", i, obs_instr, w); end
            if (obs_pc !== exp_addr) begin failures++; $display("FAIL rnd%0d_pc_out: got %h expected %h", i, obs_pc, exp_addr); end
            if (obs_lv !== exp_lv) begin failures++; $display("FAIL rnd%0d_link_valid: got %b expected %b", i, obs_lv, exp_lv); end
            if (obs_mis !== exp_mis) begin failures++; $display("FAIL rnd%0d_misalign: got %b expected %b", i, obs_mis, exp_mis); end
            if (exp_lv) begin
                checks++;
                if (obs_la !== exp_la) begin failures++; $display("FAIL rnd%0d_link_addr: got %h expected %h", i, obs_la, exp_la); end
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        bus.imem_ack = 1'b0; bus.imem_rdata = 32'h0; bus.instr_ready = 1'b0;
        drive_idle_ctrl();
        test_reset();
        test_first_fetch();
        test_straight();
        test_branch();
        test_jal();
        test_jr_wrap();
        test_reset_midflight();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
